usb_ctrl_ep_pkt: RTL and testbench

- Parametrised USB default control endpoint (EP0) for the bootloader's USB core; connects to the same out/in endpoint handshake interfaces as the existing CDC control endpoint.
- Descriptor bytes come from an external descriptor ROM port rather than an internal table.
- Splits IN data stages into MAX_PKT-sized packets and sends a terminating zero-length packet (ZLP) when required.
- STALLs unsupported requests; tracks device address and configuration value.

---
 rtl/usb_ctrl_ep_pkt.sv | 262 ++++++++++++++++++++++++++
 tb/tb_usb_ctrl_ep_pkt.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_ctrl_ep_pkt.sv
// USB default control endpoint (EP0). It decodes SETUP packets and streams descriptor bytes
// from an external ROM in MAX_PKT-sized packets. It also runs the status stages and STALLs.
module usb_ctrl_ep_pkt #(
    parameter int MAX_PKT       = 32,
    parameter int ROM_AW        = 8,
    parameter int DEV_DESC_ADDR = 0,
    parameter int DEV_DESC_LEN  = 18,
    parameter int CFG_DESC_ADDR = 18,
    parameter int CFG_DESC_LEN  = 67,
    parameter int LC_ADDR       = 85
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic [6:0]        dev_addr,
    output logic [7:0]        config_value,
    output logic              out_ep_req,
    input  logic              out_ep_grant,
    input  logic              out_ep_data_avail,
    input  logic              out_ep_setup,
    output logic              out_ep_data_get,
    input  logic [7:0]        out_ep_data,
    output logic              out_ep_stall,
    input  logic              out_ep_acked,
    output logic              in_ep_req,
    input  logic              in_ep_grant,
    input  logic              in_ep_data_free,
    output logic              in_ep_data_put,
    output logic [7:0]        in_ep_data,
    output logic              in_ep_data_done,
    output logic              in_ep_stall,
    input  logic              in_ep_acked,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [7:0]        rom_data
);

    localparam int PKT_W = $clog2(MAX_PKT) + 1;
    localparam logic [PKT_W-1:0] PKT_FULL = PKT_W'(MAX_PKT);

    typedef enum logic [2:0] {
        IDLE, SETUP, DATA_IN, DATA_OUT, STATUS_IN, STATUS_OUT, STALL
    } state_t;

    typedef enum logic [1:0] {SEL_ROM, SEL_CFG, SEL_ZERO} sel_t;

    state_t state, state_nxt;

    logic              avail_p1, vld_p1, fall_p1;
    logic [3:0]        setup_cnt;
    logic [7:0]        breq, wval_lo, wval_hi, wlen_lo, wlen_hi;
    logic [7:0]        sent, xfer_len;
    logic [PKT_W-1:0]  pkt_cnt;
    logic [15:0]       recv;
    logic [ROM_AW-1:0] rom_addr_r;
    logic              zlp_sent, done_r, pend_addr, pend_cfg;
    sel_t              data_sel;

    logic              setup_start, cap_byte, in_xfer, data_end, pkt_full, zlp_needed;
    logic [15:0]       wlen, recv_now;
    logic [7:0]        dec_len, xlen;
    logic [ROM_AW-1:0] dec_base;
    logic              dec_in, dec_stall;
    sel_t              dec_sel;

    function automatic logic [7:0] clip_len(input logic [15:0] req_len, input logic [7:0] len);
        if (req_len < {8'd0, len})
            return req_len[7:0];
        else
            return len;
    endfunction

    assign wlen        = {wlen_hi, wlen_lo};
    assign setup_start = out_ep_data_avail && !avail_p1 && out_ep_setup;
    assign cap_byte    = vld_p1 && out_ep_setup && (setup_cnt < 4'd8) && !setup_start;
    assign in_xfer     = in_ep_data_put && in_ep_grant && in_ep_data_free && !setup_start;
    assign data_end    = (sent == xfer_len);
    assign pkt_full    = (pkt_cnt == PKT_FULL);
    assign zlp_needed  = pkt_full && ({8'd0, xfer_len} < wlen);
    assign recv_now    = recv + 16'(vld_p1);

    // Request decode from the captured setup bytes; an incomplete setup is stalled.
    always_comb begin
        dec_base  = '0;
        dec_len   = 8'd0;
        dec_in    = 1'b0;
        dec_stall = 1'b0;
        dec_sel   = SEL_ROM;
        case (breq)
            8'h06: begin
                dec_in = 1'b1;
                case (wval_hi)
                    8'h01: begin dec_base = ROM_AW'(DEV_DESC_ADDR); dec_len = 8'(DEV_DESC_LEN); end
                    8'h02: begin dec_base = ROM_AW'(CFG_DESC_ADDR); dec_len = 8'(CFG_DESC_LEN); end
                    default: dec_stall = 1'b1;
                endcase
            end
            8'h21: begin dec_in = 1'b1; dec_base = ROM_AW'(LC_ADDR); dec_len = 8'd7; end
            8'h08: begin dec_in = 1'b1; dec_len = 8'd1; dec_sel = SEL_CFG; end
            8'h00: begin dec_in = 1'b1; dec_len = 8'd2; dec_sel = SEL_ZERO; end
            8'h05, 8'h09, 8'h20, 8'h22, 8'h23: ;
            default: dec_stall = 1'b1;
        endcase
        if (setup_cnt != 4'd8)
            dec_stall = 1'b1;
        xlen = clip_len(wlen, dec_len);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (setup_start) begin
            state_nxt = SETUP;
        end else begin
            case (state)
                SETUP:
                    if (fall_p1) begin
                        if (dec_stall)
                            state_nxt = STALL;
                        else if (dec_in && xlen != 8'd0)
                            state_nxt = DATA_IN;
                        else if (!dec_in && wlen != 16'd0)
                            state_nxt = DATA_OUT;
                        else
                            state_nxt = STATUS_IN;
                    end
                DATA_IN:
                    if (in_ep_acked && data_end && (zlp_sent || !zlp_needed))
                        state_nxt = STATUS_OUT;
                DATA_OUT:
                    if (out_ep_acked && recv_now >= wlen)
                        state_nxt = STATUS_IN;
                STATUS_IN:
                    if (in_ep_acked)
                        state_nxt = IDLE;
                STATUS_OUT:
                    if (out_ep_acked)
                        state_nxt = IDLE;
                default: ;
            endcase
        end
    end

    always_comb begin
        in_ep_data_put = (state == DATA_IN) && (pkt_cnt < PKT_FULL) && (sent < xfer_len);
        in_ep_req      = in_ep_data_put;
        in_ep_stall    = (state == STALL);
        out_ep_stall   = (state == STALL);
    end

    // Setup bytes are valid one cycle after the get; only the fields the decoder uses are kept.
    always_ff @(posedge clk) begin
        if (cap_byte) begin
            case (setup_cnt[2:0])
                3'd1: breq    <= out_ep_data;
                3'd2: wval_lo <= out_ep_data;
                3'd3: wval_hi <= out_ep_data;
                3'd6: wlen_lo <= out_ep_data;
                3'd7: wlen_hi <= out_ep_data;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            avail_p1     <= 1'b0;
            vld_p1       <= 1'b0;
            fall_p1      <= 1'b0;
            setup_cnt    <= 4'd0;
            sent         <= 8'd0;
            xfer_len     <= 8'd0;
            pkt_cnt      <= '0;
            recv         <= 16'd0;
            rom_addr_r   <= '0;
            zlp_sent     <= 1'b0;
            done_r       <= 1'b0;
            pend_addr    <= 1'b0;
            pend_cfg     <= 1'b0;
            data_sel     <= SEL_ROM;
            dev_addr     <= 7'd0;
            config_value <= 8'd0;
        end else begin
            avail_p1 <= out_ep_data_avail;
            vld_p1   <= out_ep_data_avail && out_ep_grant;
            fall_p1  <= avail_p1 && !out_ep_data_avail;
            done_r   <= 1'b0;
            if (setup_start) begin
                setup_cnt <= 4'd0;
                sent      <= 8'd0;
                pkt_cnt   <= '0;
                recv      <= 16'd0;
                zlp_sent  <= 1'b0;
                pend_addr <= 1'b0;
                pend_cfg  <= 1'b0;
            end else begin
                if (cap_byte)
                    setup_cnt <= setup_cnt + 4'd1;
                // Every entry into STATUS_IN answers the host with a zero-length packet.
                if (state != STATUS_IN && state_nxt == STATUS_IN)
                    done_r <= 1'b1;
                case (state)
                    SETUP:
                        if (fall_p1 && !dec_stall) begin
                            rom_addr_r <= dec_base;
                            xfer_len   <= xlen;
                            data_sel   <= dec_sel;
                            pend_addr  <= (breq == 8'h05);
                            pend_cfg   <= (breq == 8'h09);
                        end
                    DATA_IN: begin
                        if (in_xfer) begin
                            rom_addr_r <= rom_addr_r + ROM_AW'(1);
                            sent       <= sent + 8'd1;
                            pkt_cnt    <= pkt_cnt + PKT_W'(1);
                            if (pkt_cnt + PKT_W'(1) == PKT_FULL || sent + 8'd1 == xfer_len)
                                done_r <= 1'b1;
                        end
                        if (in_ep_acked) begin
                            pkt_cnt <= '0;
                            if (data_end && !zlp_sent && zlp_needed) begin
                                done_r   <= 1'b1;
                                zlp_sent <= 1'b1;
                            end
                        end
                    end
                    DATA_OUT:
                        if (vld_p1)
                            recv <= recv + 16'd1;
                    STATUS_IN:
                        if (in_ep_acked) begin
                            if (pend_addr)
                                dev_addr <= wval_lo[6:0];
                            if (pend_cfg)
                                config_value <= wval_lo;
                            pend_addr <= 1'b0;
                            pend_cfg  <= 1'b0;
                        end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        case (data_sel)
            SEL_CFG:  in_ep_data = config_value;
            SEL_ZERO: in_ep_data = 8'h00;
            default:  in_ep_data = rom_data;
        endcase
    end

    assign out_ep_req      = out_ep_data_avail;
    assign out_ep_data_get = out_ep_data_avail;
    assign in_ep_data_done = done_r;
    assign rom_addr        = rom_addr_r;

endmodule

// File: tb/tb_usb_ctrl_ep_pkt.sv
// Directed bench for usb_ctrl_ep_pkt: a default instance plus one with a 64-byte config
// descriptor, so that the zero-length-packet case is exercised.
module tb_usb_ctrl_ep_pkt;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       out_ep_grant = 0, out_ep_data_avail = 0, out_ep_setup = 0, out_ep_acked = 0;
    logic [7:0] out_ep_data = 8'h00;
    logic       in_ep_grant = 1, in_ep_data_free = 1, in_ep_acked = 0;

    logic [6:0] dev_addr, dev_addr2;
    logic [7:0] config_value, config_value2;
    logic       out_ep_req, out_ep_data_get, out_ep_stall, in_ep_req, in_ep_data_put;
    logic       in_ep_data_done, in_ep_stall;
    logic [7:0] in_ep_data, rom_addr, rom_data;
    logic       out_ep_req2, out_ep_data_get2, out_ep_stall2, in_ep_req2, in_ep_data_put2;
    logic       in_ep_data_done2, in_ep_stall2;
    logic [7:0] in_ep_data2, rom_addr2, rom_data2;

    int errors = 0;
    int checks = 0;
    logic dsel = 1'b0;

    always #5 clk = ~clk;

    function automatic logic [7:0] rom_f(input logic [7:0] a);
        return a * 8'd3 + 8'd1;
    endfunction

    function automatic logic [63:0] mk(input logic [7:0] b0, b1, b2, b3, b4, b5, b6, b7);
        return {b7, b6, b5, b4, b3, b2, b1, b0};
    endfunction

    assign rom_data  = rom_f(rom_addr);
    assign rom_data2 = rom_f(rom_addr2);

    wire       obs_put  = dsel ? in_ep_data_put2  : in_ep_data_put;
    wire       obs_done = dsel ? in_ep_data_done2 : in_ep_data_done;
    wire [7:0] obs_addr = dsel ? rom_addr2        : rom_addr;
    wire [7:0] obs_data = dsel ? in_ep_data2      : in_ep_data;

    usb_ctrl_ep_pkt dut (
        .clk(clk), .reset_n(reset_n), .dev_addr(dev_addr), .config_value(config_value),
        .out_ep_req(out_ep_req), .out_ep_grant(out_ep_grant),
        .out_ep_data_avail(out_ep_data_avail), .out_ep_setup(out_ep_setup),
        .out_ep_data_get(out_ep_data_get), .out_ep_data(out_ep_data),
        .out_ep_stall(out_ep_stall), .out_ep_acked(out_ep_acked),
        .in_ep_req(in_ep_req), .in_ep_grant(in_ep_grant), .in_ep_data_free(in_ep_data_free),
        .in_ep_data_put(in_ep_data_put), .in_ep_data(in_ep_data),
        .in_ep_data_done(in_ep_data_done), .in_ep_stall(in_ep_stall),
        .in_ep_acked(in_ep_acked), .rom_addr(rom_addr), .rom_data(rom_data)
    );

    usb_ctrl_ep_pkt #(.CFG_DESC_LEN(64), .LC_ADDR(82)) dut2 (
        .clk(clk), .reset_n(reset_n), .dev_addr(dev_addr2), .config_value(config_value2),
        .out_ep_req(out_ep_req2), .out_ep_grant(out_ep_grant),
        .out_ep_data_avail(out_ep_data_avail), .out_ep_setup(out_ep_setup),
        .out_ep_data_get(out_ep_data_get2), .out_ep_data(out_ep_data),
        .out_ep_stall(out_ep_stall2), .out_ep_acked(out_ep_acked),
        .in_ep_req(in_ep_req2), .in_ep_grant(in_ep_grant), .in_ep_data_free(in_ep_data_free),
        .in_ep_data_put(in_ep_data_put2), .in_ep_data(in_ep_data2),
        .in_ep_data_done(in_ep_data_done2), .in_ep_stall(in_ep_stall2),
        .in_ep_acked(in_ep_acked), .rom_addr(rom_addr2), .rom_data(rom_data2)
    );

    task automatic send_setup(input logic [63:0] pkt, input logic ack_start);
        for (int i = 0; i <= 8; i++) begin
            @(negedge clk);
            out_ep_setup      = 1'b1;
            out_ep_grant      = 1'b1;
            out_ep_data_avail = (i < 8);
            out_ep_data       = (i > 0) ? pkt[8*(i-1) +: 8] : 8'h00;
            in_ep_acked       = (i == 0) ? ack_start : 1'b0;
        end
        @(negedge clk);
        out_ep_setup = 1'b0;
        out_ep_grant = 1'b0;
        out_ep_data  = 8'h00;
    endtask

    // Collects npk IN packets, acking each one a few cycles after its done pulse.
    task automatic run_in(input string name, input logic d2, input int npk,
                          input int l0, input int l1, input int l2,
                          input int base, input int cval);
        int lens[3];
        int exp_addr, cnt, bad, quiet;
        logic got;
        logic [7:0] exp_d;
        lens = '{l0, l1, l2};
        dsel = d2;
        exp_addr = base;
        @(negedge clk);
        for (int p = 0; p < npk; p++) begin
            cnt = 0; got = 1'b0; bad = 0;
            for (int c = 0; c < 200 && !got; c++) begin
                if (obs_done) begin
                    got = 1'b1;
                end else begin
                    if (obs_put) begin
                        exp_d = (cval < 0) ? rom_f(exp_addr[7:0]) : cval[7:0];
                        if (obs_addr !== exp_addr[7:0] || obs_data !== exp_d) bad++;
                        cnt++;
                        exp_addr++;
                    end
                    @(negedge clk);
                end
            end
            checks++;
            if (!got || cnt != lens[p]) begin
                errors++;
                $display("FAIL %s pkt%0d length: got %0d bytes (done seen=%0b), expected %0d",
                         name, p, cnt, got, lens[p]);
            end
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL %s pkt%0d addr/data: %0d wrong bytes, expected 0", name, p, bad);
            end
            quiet = 0;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                if (obs_put || obs_done) quiet++;
            end
            checks++;
            if (quiet != 0) begin
                errors++;
                $display("FAIL %s pkt%0d wait-ack: %0d busy cycles before ack, expected 0",
                         name, p, quiet);
            end
            in_ep_acked = 1'b1;
            @(negedge clk);
            in_ep_acked = 1'b0;
        end
        quiet = 0;
        for (int k = 0; k < 4; k++) begin
            if (obs_put || obs_done) quiet++;
            @(negedge clk);
        end
        checks++;
        if (quiet != 0) begin
            errors++;
            $display("FAIL %s status-out: %0d busy cycles after last packet, expected 0", name, quiet);
        end
        out_ep_acked = 1'b1;
        @(negedge clk);
        out_ep_acked = 1'b0;
        dsel = 1'b0;
    endtask

    task automatic test_reset;
        checks++;
        if ({dev_addr, config_value, in_ep_req, in_ep_data_put, in_ep_data_done,
             in_ep_stall, out_ep_stall, rom_addr} !== 30'd0) begin
            errors++;
            $display("FAIL reset dut: dev_addr=%h cfg=%h req=%b put=%b done=%b stall=%b%b rom=%h, expected all 0",
                     dev_addr, config_value, in_ep_req, in_ep_data_put, in_ep_data_done,
                     in_ep_stall, out_ep_stall, rom_addr);
        end
        checks++;
        if ({dev_addr2, config_value2, in_ep_req2, in_ep_data_put2, in_ep_data_done2,
             in_ep_stall2, out_ep_stall2, rom_addr2, out_ep_req2, out_ep_data_get2} !== 32'd0) begin
            errors++;
            $display("FAIL reset dut2: outputs not all 0 (dev_addr=%h cfg=%h rom=%h)",
                     dev_addr2, config_value2, rom_addr2);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({in_ep_req, in_ep_data_done, in_ep_stall, out_ep_stall} !== 4'b0) begin
            errors++;
            $display("FAIL reset idle: req/done/stalls=%b, expected 0000",
                     {in_ep_req, in_ep_data_done, in_ep_stall, out_ep_stall});
        end
    endtask

    task automatic test_dev_desc;
        send_setup(mk(8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00), 1'b0);
        run_in("dev_desc", 1'b0, 1, 18, 0, 0, 0, -1);
    endtask

    task automatic test_cfg_desc;
        send_setup(mk(8'h80, 8'h06, 8'h00, 8'h02, 8'h00, 8'h00, 8'hFF, 8'h00), 1'b0);
        run_in("cfg_desc", 1'b0, 3, 32, 32, 3, 18, -1);
    endtask

    task automatic test_zlp;
        send_setup(mk(8'h80, 8'h06, 8'h00, 8'h02, 8'h00, 8'h00, 8'hFF, 8'h00), 1'b0);
        run_in("cfg64_zlp", 1'b1, 3, 32, 32, 0, 18, -1);
        send_setup(mk(8'h80, 8'h06, 8'h00, 8'h02, 8'h00, 8'h00, 8'h40, 8'h00), 1'b0);
        run_in("cfg64_nozlp", 1'b1, 2, 32, 32, 0, 18, -1);
    endtask

    task automatic test_set_address;
        send_setup(mk(8'h00, 8'h05, 8'h2A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00), 1'b0);
        @(negedge clk);
        checks++;
        if (in_ep_data_done !== 1'b1 || dev_addr !== 7'h00) begin
            errors++;
            $display("FAIL set_addr zlp: done=%b dev_addr=%h, expected done=1 dev_addr=00",
                     in_ep_data_done, dev_addr);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (in_ep_data_done !== 1'b0 || dev_addr !== 7'h00) begin
            errors++;
            $display("FAIL set_addr early: done=%b dev_addr=%h, expected 0/00", in_ep_data_done, dev_addr);
        end
        in_ep_acked = 1'b1;
        @(negedge clk);
        in_ep_acked = 1'b0;
        checks++;
        if (dev_addr !== 7'h2A) begin
            errors++;
            $display("FAIL set_addr apply: dev_addr=%h, expected 2a", dev_addr);
        end
    endtask

    task automatic test_get_config;
        send_setup(mk(8'h00, 8'h09, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00), 1'b0);
        @(negedge clk);
        checks++;
        if (in_ep_data_done !== 1'b1 || config_value !== 8'h00) begin
            errors++;
            $display("FAIL set_cfg zlp: done=%b cfg=%h, expected 1/00", in_ep_data_done, config_value);
        end
        in_ep_acked = 1'b1;
        @(negedge clk);
        in_ep_acked = 1'b0;
        checks++;
        if (config_value !== 8'h01) begin
            errors++;
            $display("FAIL set_cfg apply: cfg=%h, expected 01", config_value);
        end
        send_setup(mk(8'h80, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00), 1'b0);
        run_in("get_cfg", 1'b0, 1, 1, 0, 0, 0, 1);
    endtask

    task automatic test_get_status;
        send_setup(mk(8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00), 1'b0);
        run_in("get_status", 1'b0, 1, 2, 0, 0, 0, 0);
    endtask

    task automatic test_data_out;
        send_setup(mk(8'h21, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h07, 8'h00), 1'b0);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            out_ep_data_avail = 1'b1;
            out_ep_grant = 1'b1;
            out_ep_data = 8'(i + 8'h40);
        end
        checks++;
        if (out_ep_req !== 1'b1 || out_ep_data_get !== 1'b1) begin
            errors++;
            $display("FAIL out_req: req=%b get=%b, expected 1/1", out_ep_req, out_ep_data_get);
        end
        @(negedge clk);
        out_ep_data_avail = 1'b0;
        out_ep_grant = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ep_data_done !== 1'b0 || in_ep_stall !== 1'b0) begin
            errors++;
            $display("FAIL data_out early: done=%b stall=%b, expected 0/0", in_ep_data_done, in_ep_stall);
        end
        out_ep_acked = 1'b1;
        @(negedge clk);
        out_ep_acked = 1'b0;
        checks++;
        if (in_ep_data_done !== 1'b1) begin
            errors++;
            $display("FAIL data_out zlp: done=%b, expected 1", in_ep_data_done);
        end
        in_ep_acked = 1'b1;
        @(negedge clk);
        in_ep_acked = 1'b0;
    endtask

    task automatic test_stall;
        send_setup(mk(8'h80, 8'h0B, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00), 1'b0);
        @(negedge clk);
        checks++;
        if ({in_ep_stall, out_ep_stall, in_ep_req} !== 3'b110) begin
            errors++;
            $display("FAIL stall set: stall_in/out/req=%b, expected 110", {in_ep_stall, out_ep_stall, in_ep_req});
        end
        repeat (5) @(negedge clk);
        checks++;
        if ({in_ep_stall, out_ep_stall} !== 2'b11) begin
            errors++;
            $display("FAIL stall hold: stalls=%b, expected 11", {in_ep_stall, out_ep_stall});
        end
        send_setup(mk(8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00), 1'b0);
        checks++;
        if ({in_ep_stall, out_ep_stall} !== 2'b00) begin
            errors++;
            $display("FAIL stall clear: stalls=%b, expected 00", {in_ep_stall, out_ep_stall});
        end
        run_in("after_stall", 1'b0, 1, 18, 0, 0, 0, -1);
        send_setup(mk(8'h80, 8'h06, 8'h00, 8'h03, 8'h00, 8'h00, 8'h40, 8'h00), 1'b0);
        @(negedge clk);
        checks++;
        if ({in_ep_stall, out_ep_stall} !== 2'b11) begin
            errors++;
            $display("FAIL stall desc3: stalls=%b, expected 11", {in_ep_stall, out_ep_stall});
        end
    endtask

    task automatic test_setup_vs_ack;
        send_setup(mk(8'h00, 8'h05, 8'h15, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00), 1'b0);
        @(negedge clk);
        checks++;
        if (in_ep_data_done !== 1'b1) begin
            errors++;
            $display("FAIL setup_vs_ack zlp: done=%b, expected 1", in_ep_data_done);
        end
        send_setup(mk(8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00), 1'b1);
        run_in("setup_vs_ack", 1'b0, 1, 2, 0, 0, 0, 0);
        checks++;
        if (dev_addr !== 7'h2A) begin
            errors++;
            $display("FAIL setup_vs_ack addr: dev_addr=%h, expected 2a", dev_addr);
        end
    endtask

    task automatic test_reset_async;
        send_setup(mk(8'h80, 8'h06, 8'h00, 8'h02, 8'h00, 8'h00, 8'hFF, 8'h00), 1'b0);
        repeat (5) @(negedge clk);
        checks++;
        if (in_ep_data_put !== 1'b1 || config_value !== 8'h01) begin
            errors++;
            $display("FAIL pre_reset: put=%b cfg=%h, expected 1/01", in_ep_data_put, config_value);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({dev_addr, config_value, in_ep_req, in_ep_data_put, in_ep_data_done,
             in_ep_stall, out_ep_stall, rom_addr} !== 30'd0) begin
            errors++;
            $display("FAIL async_reset: dev_addr=%h cfg=%h req=%b put=%b done=%b rom=%h, expected all 0",
                     dev_addr, config_value, in_ep_req, in_ep_data_put, in_ep_data_done, rom_addr);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #1;
        test_reset();
        test_dev_desc();
        test_cfg_desc();
        test_zlp();
        test_set_address();
        test_get_config();
        test_get_status();
        test_data_out();
        test_stall();
        test_setup_vs_ack();
        test_reset_async();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
